// File: rtl/spi_sample_tx.sv
// SPI mode-0 slave transmitter: captures one sample from the datapath sequencer
// and holds transmit high until the MCU has clocked the word out MSB first.
module spi_sample_tx #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sck,
    input  logic              cs_n,
    output logic              sdo,
    output logic              sdo_en,
    output logic              transmit,
    output logic              tx_done,
    output logic              tx_abort
);

    localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
    localparam int unsigned TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [DATA_W-1:0]   shreg, shreg_d;
    logic [CNT_W-1:0]    bitcnt, bitcnt_d, cnt_v;
    logic [TO_W-1:0]     tocnt, tocnt_d;
    logic                ok, ok_d;

    // [0],[1] synchronize; [2] holds the previous synchronized level for edge detect
    logic [2:0] sck_sr, cs_sr;
    logic       sck_rise, sck_fall, cs_fall, cs_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sr <= 3'b000;
            cs_sr  <= 3'b111;
        end else begin
            sck_sr <= {sck_sr[1:0], sck};
            cs_sr  <= {cs_sr[1:0], cs_n};
        end
    end

    assign sck_rise =  sck_sr[1] & ~sck_sr[2];
    assign sck_fall = ~sck_sr[1] &  sck_sr[2];
    assign cs_fall  = ~cs_sr[1]  &  cs_sr[2];
    assign cs_rise  =  cs_sr[1]  & ~cs_sr[2];

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            tocnt  <= '0;
            ok     <= 1'b0;
        end else begin
            state  <= state_d;
            shreg  <= shreg_d;
            bitcnt <= bitcnt_d;
            tocnt  <= tocnt_d;
            ok     <= ok_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state;
        shreg_d  = shreg;
        bitcnt_d = bitcnt;
        tocnt_d  = tocnt;
        ok_d     = ok;
        cnt_v    = bitcnt;
        case (state)
            IDLE: begin
                if (load) begin
                    shreg_d  = sample_in;
                    bitcnt_d = '0;
                    tocnt_d  = '0;
                    ok_d     = 1'b0;
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                end else begin
                    tocnt_d = tocnt + TO_W'(1);
                    if ((TIMEOUT_CYC != 0) && (tocnt == TO_W'(TO_LAST))) begin
                        ok_d    = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                if (sck_rise && (bitcnt != CNT_W'(DATA_W)))
                    cnt_v = bitcnt + CNT_W'(1);
                bitcnt_d = cnt_v;
                // past the last bit the register is cleared so sdo idles at 0
                if (sck_fall) begin
                    if ((bitcnt >= CNT_W'(1)) && (bitcnt < CNT_W'(DATA_W)))
                        shreg_d = {shreg[DATA_W-2:0], 1'b0};
                    else if (bitcnt == CNT_W'(DATA_W))
                        shreg_d = '0;
                end
                // completion judged on the count including a same-cycle sck_rise
                if (cs_rise) begin
                    ok_d    = (cnt_v == CNT_W'(DATA_W));
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign transmit = ((state == IDLE) && load) || (state == ARMED) || (state == SHIFT);
    assign sdo      = ((state == ARMED) || (state == SHIFT)) ? shreg[DATA_W-1] : 1'b0;
    assign sdo_en   = ~cs_sr[1];
    assign tx_done  = (state == DONE) &&  ok;
    assign tx_abort = (state == DONE) && !ok;

endmodule
